// File: rtl/store_pkg.sv
// store_pkg: shared store encodings, buffer entry layout and controller states
package store_pkg;
  localparam int SB_AW = 32;
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
  } sb_entry_t;
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: lane-replicates store data, builds byte strobes, flags misalignment
module store_lane_fmt
  import store_pkg::*;
(
  input  logic [1:0]  ctrl,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misalign
);
  // byte and half accesses replicate data across lanes; 11 behaves as a word
  always_comb begin
    misalign = (ctrl == ST_SB) ? 1'b0 : (ctrl == ST_SH) ? a[0] : |a;
    wdata    = (ctrl == ST_SB) ? {4{d[7:0]}} : (ctrl == ST_SH) ? {2{d[15:0]}} : d;
    wstrb    = (ctrl == ST_SB) ? 4'b0001 << a : (ctrl == ST_SH) ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  end
endmodule

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: posted-write FIFO draining formatted stores to memory over req/ack
module store_buffer_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    st_ctrl,
  output logic          st_misalign,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic          mem_ack,
  output logic          sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  sb_entry_t        fifo_q [DEPTH];
  sb_entry_t        fifo_d [DEPTH];
  sb_entry_t        out_q, out_d, new_e, nxt_e;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic             req_q, req_d, mis_q, mis_d, push, pop, fmt_mis;
  logic [31:0]      fmt_wdata;
  logic [3:0]       fmt_wstrb;
  logic [AW-1:0]    haddr;

  store_lane_fmt u_fmt (
    .ctrl    (st_ctrl),
    .a       (st_addr[1:0]),
    .d       (st_data),
    .wdata   (fmt_wdata),
    .wstrb   (fmt_wstrb),
    .misalign(fmt_mis)
  );

  assign st_ready    = count_q != CW'(DEPTH);
  assign st_misalign = mis_q;
  assign mem_req     = req_q;
  assign mem_addr    = AW'(out_q.addr);
  assign mem_wdata   = out_q.wdata;
  assign mem_wstrb   = out_q.wstrb;
  assign sb_empty    = (count_q == '0) && !req_q;

  // enqueue/dequeue bookkeeping and issue FSM; an ack with a successor reloads the head
  // the same edge, forwarding a store pushed this cycle when it is the only successor
  always_comb begin
    new_e    = '{addr: SB_AW'({st_addr[AW-1:2], 2'b00}), wdata: fmt_wdata, wstrb: fmt_wstrb};
    push     = st_valid && st_ready && !fmt_mis;
    pop      = (state_q == S_ISSUE) && mem_ack;
    mis_d    = st_valid && st_ready && fmt_mis;
    fifo_d   = fifo_q;
    if (push) fifo_d[wr_ptr_q] = new_e;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    nxt_e    = (count_q > CW'(1)) ? fifo_q[rd_ptr_q + PW'(1)] : new_e;
    state_d  = state_q;
    req_d    = req_q;
    out_d    = out_q;
    if (state_q == S_IDLE && count_q != '0) begin
      state_d = S_ISSUE;
      req_d   = 1'b1;
      out_d   = fifo_q[rd_ptr_q];
    end else if (pop) begin
      state_d = (count_q > CW'(1) || push) ? S_ISSUE : S_IDLE;
      req_d   = count_q > CW'(1) || push;
      out_d   = (count_q > CW'(1) || push) ? nxt_e : out_q;
    end
  end

  // word-address match against every occupied slot, head included
  always_comb begin
    ld_hazard = 1'b0;
    off       = '0;
    haddr     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off   = PW'(i) - rd_ptr_q;
      haddr = AW'(fifo_q[i].addr);
      if ({1'b0, off} < count_q && (haddr | AW'(ld_addr[1:0])) == ld_addr) ld_hazard = 1'b1;
    end
  end

  // state registers; reset discards every entry and drops any outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q   <= '{default: '0};
      out_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      out_q    <= out_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      req_q    <= req_d;
      mis_q    <= mis_d;
    end
  end
endmodule
